// File: rtl/bc_msg_arbiter.sv
// Round-robin arbiter sharing one broadcast-message channel among cores; BC_MSG_STATS_EN adds bc_msg_count.
// Latency: 2 cycles from input handshake to bc_msg_out_valid; 1 message/cycle aggregate throughput.
// Backpressure: per-core ready decoded from registered FIFO count; the broadcast output is never stalled.
module bc_msg_arbiter #(
    parameter int CORE_COUNT    = 16,
    parameter int CORE_ID_WIDTH = 4,
    parameter int MSG_WIDTH     = 46,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg,
    input  logic [CORE_COUNT-1:0]           core_msg_valid,
    output logic [CORE_COUNT-1:0]           core_msg_ready,
    output logic [MSG_WIDTH-1:0]            bc_msg_out,
    output logic                            bc_msg_out_valid,
    output logic [CORE_ID_WIDTH-1:0]        bc_msg_src
`ifdef BC_MSG_STATS_EN
    ,
    output logic [31:0]                     bc_msg_count
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [MSG_WIDTH-1:0]     mem_q    [CORE_COUNT][FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q [CORE_COUNT];
    logic [PTR_W-1:0]         rd_ptr_q [CORE_COUNT];
    logic [CNT_W-1:0]         cnt_q    [CORE_COUNT];
    logic [CNT_W-1:0]         cnt_d    [CORE_COUNT];

    logic [CORE_COUNT-1:0]    push;
    logic [CORE_COUNT-1:0]    pop;
    logic [CORE_COUNT-1:0]    not_empty;
    logic [2*CORE_COUNT-1:0]  req_dbl;
    logic [CORE_COUNT-1:0]    req_rot;
    logic                     grant_vld;
    logic [CORE_ID_WIDTH-1:0] grant_idx;
    logic [MSG_WIDTH-1:0]     grant_msg;
    logic [CORE_ID_WIDTH-1:0] rr_ptr_q;
    logic [CORE_ID_WIDTH-1:0] rr_ptr_d;
    logic [MSG_WIDTH-1:0]     out_msg_q;
    logic                     out_vld_q;
    logic [CORE_ID_WIDTH-1:0] out_src_q;

    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            core_msg_ready[i] = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
            not_empty[i]      = (cnt_q[i] != '0);
        end
    end

    assign push = core_msg_valid & core_msg_ready;

    // Rotating the request vector by the pointer turns the wrapped search into a plain priority scan.
    assign req_dbl = {not_empty, not_empty} >> rr_ptr_q;
    assign req_rot = req_dbl[CORE_COUNT-1:0];

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            if (!grant_vld && req_rot[k]) begin
                grant_vld = 1'b1;
                grant_idx = CORE_ID_WIDTH'((int'(rr_ptr_q) + k) % CORE_COUNT);
            end
        end
    end

    always_comb begin
        pop       = '0;
        grant_msg = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (grant_vld && (grant_idx == CORE_ID_WIDTH'(i))) begin
                pop[i]    = 1'b1;
                grant_msg = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    assign rr_ptr_d = grant_vld ? CORE_ID_WIDTH'((int'(grant_idx) + 1) % CORE_COUNT) : rr_ptr_q;

    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rr_ptr_q  <= '0;
            out_vld_q <= 1'b0;
            out_msg_q <= '0;
            out_src_q <= '0;
            for (int i = 0; i < CORE_COUNT; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            out_vld_q <= grant_vld;
            if (grant_vld) begin
                out_msg_q <= grant_msg;
                out_src_q <= grant_idx;
            end
            for (int i = 0; i < CORE_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                end
            end
        end
    end

    // Payload storage carries no reset; occupancy is governed solely by the counters.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (sys_rst_n && push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= core_msg[i*MSG_WIDTH +: MSG_WIDTH];
            end
        end
    end

    assign bc_msg_out       = out_msg_q;
    assign bc_msg_out_valid = out_vld_q;
    assign bc_msg_src       = out_src_q;

`ifdef BC_MSG_STATS_EN
    logic [31:0] bc_msg_count_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bc_msg_count_q <= '0;
        end else if (out_vld_q) begin
            bc_msg_count_q <= bc_msg_count_q + 32'd1;
        end
    end

    assign bc_msg_count = bc_msg_count_q;
`endif

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Directed bench for bc_msg_arbiter: vector table plus hand sequences with a per-core scoreboard.
module tb_bc_msg_arbiter;
    localparam int NC  = 16;
    localparam int IDW = 4;
    localparam int MW  = 46;
    localparam int FD  = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic [NC*MW-1:0] core_msg;
    logic [NC-1:0]    core_msg_valid;
    logic [NC-1:0]    core_msg_ready;
    logic [MW-1:0]    bc_msg_out;
    logic             bc_msg_out_valid;
    logic [IDW-1:0]   bc_msg_src;
`ifdef BC_MSG_STATS_EN
    logic [31:0]      bc_msg_count;
`endif

    bc_msg_arbiter #(
        .CORE_COUNT    (NC),
        .CORE_ID_WIDTH (IDW),
        .MSG_WIDTH     (MW),
        .FIFO_DEPTH    (FD)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .core_msg         (core_msg),
        .core_msg_valid   (core_msg_valid),
        .core_msg_ready   (core_msg_ready),
        .bc_msg_out       (bc_msg_out),
        .bc_msg_out_valid (bc_msg_out_valid),
        .bc_msg_src       (bc_msg_src)
`ifdef BC_MSG_STATS_EN
        ,
        .bc_msg_count     (bc_msg_count)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [NC-1:0] vld;
        logic          ev;
        int            es;
    } vec_t;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [MW-1:0] exp_q [NC][$];
    int            sent  [NC];
    vec_t          tbl   [27];

    // Message layout used by the bench: {addr[9:0], strb[3:0], data[31:0]}.
    function automatic logic [MW-1:0] mk(input int c, input int n);
        return {10'((c << 5) + (n & 31)), 4'((c + n) & 15), 32'((c << 24) | n)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_msg(input string name, input int s);
        logic [MW-1:0] e;
        if (exp_q[s].size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_sb: got message 0x%0h from core %0d, expected none queued", name, bc_msg_out, s);
        end else begin
            e = exp_q[s].pop_front();
            chk({name, "_msg"}, 64'(bc_msg_out), 64'(e));
        end
    endtask

    task automatic chk_out(input string name, input logic ev, input int es);
        chk({name, "_vld"}, 64'(bc_msg_out_valid), 64'(ev));
        if (ev) begin
            chk({name, "_src"}, 64'(bc_msg_src), 64'(es));
            chk_msg(name, es);
        end
    endtask

    // Drive one cycle of stimulus from a negedge, through the posedge, back to the next negedge.
    task automatic step(input logic [NC-1:0] vmask);
        logic [NC-1:0] acc;
        for (int c = 0; c < NC; c++) core_msg[c*MW +: MW] = mk(c, sent[c]);
        core_msg_valid = vmask;
        acc = vmask & core_msg_ready;
        @(posedge sys_clk);
        for (int c = 0; c < NC; c++) begin
            if (acc[c]) begin
                exp_q[c].push_back(mk(c, sent[c]));
                sent[c]++;
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        core_msg_valid = '0;
        sys_rst_n      = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int c = 0; c < NC; c++) exp_q[c].delete();
    endtask

    initial begin
        logic [NC-1:0] seen_low;
        logic [MW-1:0] m;
        int            left;

        tbl[0] = '{vld: 16'hFFFF, ev: 1'b0, es: 0};
        for (int k = 1; k <= 16; k++) tbl[k] = '{vld: 16'h0000, ev: 1'b1, es: k - 1};
        tbl[17] = '{vld: 16'h0000, ev: 1'b0, es: 0};
        tbl[18] = '{vld: 16'h0020, ev: 1'b0, es: 0};
        tbl[19] = '{vld: 16'h0088, ev: 1'b1, es: 5};
        tbl[20] = '{vld: 16'h0000, ev: 1'b1, es: 7};
        tbl[21] = '{vld: 16'h0000, ev: 1'b1, es: 3};
        tbl[22] = '{vld: 16'h0038, ev: 1'b0, es: 0};
        tbl[23] = '{vld: 16'h0000, ev: 1'b1, es: 4};
        tbl[24] = '{vld: 16'h0000, ev: 1'b1, es: 5};
        tbl[25] = '{vld: 16'h0000, ev: 1'b1, es: 3};
        tbl[26] = '{vld: 16'h0000, ev: 1'b0, es: 0};

        for (int c = 0; c < NC; c++) sent[c] = 0;
        sys_rst_n      = 1'b0;
        core_msg       = '0;
        core_msg_valid = '0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_vld", 64'(bc_msg_out_valid), 64'(0));
        chk("rst_msg", 64'(bc_msg_out), 64'(0));
        chk("rst_src", 64'(bc_msg_src), 64'(0));
        chk("rst_rdy", 64'(core_msg_ready), 64'(16'hFFFF));
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Single message from core 3, exact fields.
        m = {10'h005, 4'hF, 32'h0000_0ABC};
        core_msg[3*MW +: MW] = m;
        core_msg_valid = 16'h0008;
        @(posedge sys_clk);
        @(negedge sys_clk);
        core_msg_valid = '0;
        chk("single_t1_vld", 64'(bc_msg_out_valid), 64'(0));
        chk("single_t1_rdy3", 64'(core_msg_ready[3]), 64'(1));
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("single_t2_vld", 64'(bc_msg_out_valid), 64'(1));
        chk("single_src", 64'(bc_msg_src), 64'(3));
        chk("single_data", 64'(bc_msg_out[31:0]), 64'(32'h0000_0ABC));
        chk("single_strb", 64'(bc_msg_out[35:32]), 64'(4'hF));
        chk("single_addr", 64'(bc_msg_out[45:36]), 64'(10'h005));
        chk("single_rdy3", 64'(core_msg_ready[3]), 64'(1));
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("single_t3_vld", 64'(bc_msg_out_valid), 64'(0));

        // Burst from all cores, then round-robin fairness and final pointer position.
        do_reset();
        for (int i = 0; i < 27; i++) begin
            step(tbl[i].vld);
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es);
            chk($sformatf("vec%0d_rdy", i), 64'(core_msg_ready), 64'(16'hFFFF));
        end

        // All cores backlogged: strict rotation, ready drops, nothing lost or duplicated.
        do_reset();
        seen_low = '0;
        for (int k = 0; k < 200; k++) begin
            step('1);
            seen_low |= ~core_msg_ready;
            if (k == 0) chk_out("bp0", 1'b0, 0);
            else        chk_out($sformatf("bp%0d", k), 1'b1, (k - 1) % NC);
        end
        chk("bp_ready_dropped", 64'(seen_low), 64'(16'hFFFF));
        for (int d = 0; d < 80; d++) begin
            step('0);
            if (bc_msg_out_valid) chk_msg($sformatf("drain%0d", d), int'(bc_msg_src));
        end
        left = 0;
        for (int c = 0; c < NC; c++) left += exp_q[c].size();
        chk("bp_left", 64'(left), 64'(0));
        chk("bp_idle_vld", 64'(bc_msg_out_valid), 64'(0));

        // Reset with messages queued in cores 0 and 1.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(16'h0003);
            chk_out($sformatf("mr%0d", k), k != 0, (k - 1) % 2);
        end
        core_msg_valid = '0;
        sys_rst_n      = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int c = 0; c < NC; c++) exp_q[c].delete();
        chk("mr_rst_vld", 64'(bc_msg_out_valid), 64'(0));
        chk("mr_rst_msg", 64'(bc_msg_out), 64'(0));
        chk("mr_rst_src", 64'(bc_msg_src), 64'(0));
        chk("mr_rst_rdy", 64'(core_msg_ready), 64'(16'hFFFF));
        for (int k = 0; k < 4; k++) begin
            step('0);
            chk($sformatf("mr_idle%0d_vld", k), 64'(bc_msg_out_valid), 64'(0));
        end
        step(16'h0200);
        chk_out("mr_new_t1", 1'b0, 0);
        step('0);
        chk_out("mr_new_t2", 1'b1, 9);
        step('0);
        chk_out("mr_new_t3", 1'b0, 0);

`ifdef BC_MSG_STATS_EN
        // Counter wrap.
        do_reset();
        chk("cnt_rst", 64'(bc_msg_count), 64'(0));
        force dut.bc_msg_count_q = 32'hFFFF_FFFE;
        release dut.bc_msg_count_q;
        step(16'h0004);
        chk_out("st0", 1'b0, 0);
        chk("cnt0", 64'(bc_msg_count), 64'(32'hFFFF_FFFE));
        step(16'h0004);
        chk_out("st1", 1'b1, 2);
        chk("cnt1", 64'(bc_msg_count), 64'(32'hFFFF_FFFE));
        step(16'h0004);
        chk_out("st2", 1'b1, 2);
        chk("cnt2", 64'(bc_msg_count), 64'(32'hFFFF_FFFF));
        step('0);
        chk_out("st3", 1'b1, 2);
        chk("cnt3", 64'(bc_msg_count), 64'(32'h0000_0000));
        step('0);
        chk_out("st4", 1'b0, 0);
        chk("cnt4", 64'(bc_msg_count), 64'(32'h0000_0001));
        step('0);
        chk("cnt5", 64'(bc_msg_count), 64'(32'h0000_0001));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
